// File: rtl/encoder_42_pkg.sv
// Shared definitions for the 4-to-2 priority encoder: request vector type,
// index constants and a population-count helper.
package encoder_42_pkg;

  localparam int REQ_W = 4;
  localparam int IDX_W = 2;

  // Request vector layout: bit 0 = a (lowest priority) ... bit 3 = d (highest)
  typedef logic [REQ_W-1:0] req_t;
  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t IDX_A = 2'b00;
  localparam idx_t IDX_B = 2'b01;
  localparam idx_t IDX_C = 2'b10;
  localparam idx_t IDX_D = 2'b11;

  function automatic logic [2:0] req_pop(input req_t r);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < REQ_W; i++) begin
      cnt = cnt + {2'b00, r[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/encoder_42_core.sv
// Combinational core: highest-priority index, any-request and
// multiple-request flags from the 4-bit request vector.
module encoder42_core
  import encoder_42_pkg::*;
(
  input  req_t        req_i,
  output idx_t        idx_o,
  output logic        valid_o,
  output logic        multi_o
);

  always_comb begin
    idx_o = IDX_A;
    if (req_i[3]) begin
      idx_o = IDX_D;
    end else if (req_i[2]) begin
      idx_o = IDX_C;
    end else if (req_i[1]) begin
      idx_o = IDX_B;
    end
  end

  assign valid_o = |req_i;
  assign multi_o = (req_pop(req_i) >= 3'd2);

endmodule

// File: rtl/encoder_42.sv
// Registered 4-to-2 priority encoder (d > c > b > a) with valid and
// multi-request flags; one cycle of latency, synchronous active-high reset.
module encoder_42
  import encoder_42_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic x,
  output logic y,
  output logic valid,
  output logic multi
);

  req_t req;
  idx_t idx_d, idx_q;
  logic valid_d, valid_q;
  logic multi_d, multi_q;

  assign req = {d, c, b, a};

  encoder42_core u_core (
    .req_i   (req),
    .idx_o   (idx_d),
    .valid_o (valid_d),
    .multi_o (multi_d)
  );

  // Reset wins over sampling: the sample present at a reset edge is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= IDX_A;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  assign x     = idx_q[1];
  assign y     = idx_q[0];
  assign valid = valid_q;
  assign multi = multi_q;

endmodule

// File: tb/tb_encoder_42.sv
// Self-checking bench for encoder_42: directed plan, exhaustive sweep and
// randomized traffic against a behavioural model.
module tb_encoder_42;

  logic clk = 1'b0;
  logic rst;
  logic a, b, c, d;
  logic x, y, valid, multi;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] prev_exp;
  bit         have_prev = 0;

  encoder_42 dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .x     (x),
    .y     (y),
    .valid (valid),
    .multi (multi)
  );

  always #5 clk = ~clk;

  // Model: index of the highest set request, number of set requests
  function automatic logic [3:0] ref_enc(input logic r, input logic [3:0] rq);
    int idx;
    int cnt;
    logic [1:0] idx2;
    if (r) return 4'b0000;
    idx = 0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (rq[i]) begin
        idx = i;
        cnt = cnt + 1;
      end
    end
    idx2 = idx[1:0];
    return {idx2, (cnt > 0), (cnt >= 2)};
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: {x,y,valid,multi} got %b expected %b", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs must hold until the next
  // rising edge and then reflect the sampled inputs.
  task automatic step(input logic r, input logic [3:0] rq, input string tag);
    logic [3:0] exp;
    @(negedge clk);
    rst = r;
    {d, c, b, a} = rq;
    #1;
    if (have_prev) chk({tag, "_hold"}, {x, y, valid, multi}, prev_exp);
    exp = ref_enc(r, rq);
    @(posedge clk);
    #1;
    chk(tag, {x, y, valid, multi}, exp);
    prev_exp  = exp;
    have_prev = 1;
  endtask

  initial begin
    rst = 1'b1;
    {d, c, b, a} = 4'b0000;

    // Reset with every request high, then release
    step(1'b1, 4'b1111, "rst0");
    step(1'b1, 4'b1111, "rst1");
    step(1'b0, 4'b1111, "rel");

    // Single-hot sweep and idle
    step(1'b0, 4'b0001, "hot_a");
    step(1'b0, 4'b0010, "hot_b");
    step(1'b0, 4'b0100, "hot_c");
    step(1'b0, 4'b1000, "hot_d");
    step(1'b0, 4'b0000, "idle");

    // Priority sequence
    step(1'b0, 4'b0001, "pri_a");
    step(1'b0, 4'b0101, "pri_ac");
    step(1'b0, 4'b1101, "pri_acd");
    step(1'b0, 4'b0011, "pri_ab");

    // Exhaustive
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 4'(i), $sformatf("exh%0d", i));
    end

    // Mid-stream reset with d held high
    step(1'b0, 4'b1000, "mid_pre");
    step(1'b1, 4'b1000, "mid_rst");
    step(1'b0, 4'b1000, "mid_post");

    // Randomized traffic with occasional reset
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
